reg_funsel_sequencer: RTL and testbench

Command-side driver for the team's funsel/enable registers. Accepts register operations (clear/load/decrement/increment, with a repeat count) over a valid/ready handshake and buffers them in a small FIFO. Replays each operation as clean enable pulses on a target register's funsel/e/i interface. Sits between the control unit and a register instance; the control unit issues multi-step register updates without timing each pulse itself.

---
 rtl/reg_funsel_sequencer_if.sv | 13 +
 rtl/reg_funsel_sequencer.sv | 96 +++++++++
 tb/tb_reg_funsel_sequencer.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/reg_funsel_sequencer_if.sv
// reg_funsel_sequencer_if: valid/ready command channel into reg_funsel_sequencer
interface reg_funsel_sequencer_if #(
  parameter int NBits = 16,
  parameter int CntBits = 4
);
  logic cmd_valid;
  logic cmd_ready;
  logic [1:0] cmd_op;
  logic [NBits-1:0] cmd_data;
  logic [CntBits-1:0] cmd_count;
  modport master (output cmd_valid, cmd_op, cmd_data, cmd_count, input cmd_ready);
  modport slave (input cmd_valid, cmd_op, cmd_data, cmd_count, output cmd_ready);
endinterface

// File: rtl/reg_funsel_sequencer.sv
// reg_funsel_sequencer: queues clear/load/dec/inc commands and replays them as isolated e pulses on a funsel register
// Optional `define REG_SEQ_SHADOW_EN adds shadow_q, a copy of the target's expected value.
module reg_funsel_sequencer #(
  parameter int NBits = 16,
  parameter int Depth = 4,
  parameter int CntBits = 4
) (
  input  logic clock,
  input  logic reset,
  reg_funsel_sequencer_if.slave cmd,
  output logic [1:0] funsel,
  output logic e,
  output logic [NBits-1:0] i,
  output logic busy,
  output logic done,
`ifdef REG_SEQ_SHADOW_EN
  output logic [NBits-1:0] shadow_q,
`endif
  output logic [$clog2(Depth):0] fifo_level
);
  localparam int AW = $clog2(Depth);
  localparam int W = 2 + NBits + CntBits;
  typedef enum logic [1:0] {IDLE, SETUP, PULSE, GAP} state_t;
  state_t state, state_d;
  logic [W-1:0] mem [Depth];
  logic [AW-1:0] wp, rp;
  logic [CntBits-1:0] rem, rem_d, cnt_h;
  logic [1:0] op_h;
  logic [NBits-1:0] data_h;
  logic push, pop, full, empty;
  // Depth is a power of two, so the level MSB alone marks full
  assign full = fifo_level[AW];
  assign empty = fifo_level == '0;
  assign cmd.cmd_ready = !full;
  assign push = cmd.cmd_valid && !full;
  assign {op_h, data_h, cnt_h} = mem[rp];
  assign busy = state != IDLE || !empty;
  always_ff @(posedge clock)
    if (push) mem[wp] <= {cmd.cmd_op, cmd.cmd_data, cmd.cmd_count};
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      wp <= '0;
      rp <= '0;
      fifo_level <= '0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop) rp <= rp + 1'b1;
      fifo_level <= fifo_level + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    end
  always_comb begin
    state_d = state;
    rem_d = rem;
    pop = 1'b0;
    case (state)
      IDLE: if (!empty) begin
        pop = 1'b1;
        state_d = SETUP;
      end
      SETUP: state_d = PULSE;
      PULSE: state_d = GAP;
      GAP: if (rem != '0) begin
        rem_d = rem - 1'b1;
        state_d = PULSE;
      end else begin
        pop = !empty;
        state_d = empty ? IDLE : SETUP;
      end
    endcase
    if (pop) rem_d = op_h[1] ? cnt_h : '0;
  end
  // done is registered on the PULSE->GAP edge so it lands in the final GAP cycle
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      state <= IDLE;
      rem <= '0;
      e <= 1'b0;
      done <= 1'b0;
      funsel <= 2'b00;
      i <= '0;
    end else begin
      state <= state_d;
      rem <= rem_d;
      e <= state_d == PULSE;
      done <= state == PULSE && rem == '0;
      if (pop) begin
        funsel <= op_h;
        i <= data_h;
      end
    end
`ifdef REG_SEQ_SHADOW_EN
  always_ff @(posedge clock or posedge reset)
    if (reset) shadow_q <= '0;
    else if (state == PULSE)
      shadow_q <= funsel == 2'b00 ? '0 : funsel == 2'b01 ? i : funsel[0] ? shadow_q + 1'b1 : shadow_q - 1'b1;
`endif
endmodule

// File: tb/tb_reg_funsel_sequencer.sv
// tb_reg_funsel_sequencer: scoreboard bench; each accepted command queues its expected e pulses
module tb_reg_funsel_sequencer;
  logic clock = 1'b0;
  logic reset;
  logic [1:0] funsel;
  logic e, busy, done;
  logic [15:0] i;
  logic [2:0] fifo_level;
`ifdef REG_SEQ_SHADOW_EN
  logic [15:0] shadow_q;
`endif
  reg_funsel_sequencer_if #(.NBits(16), .CntBits(4)) ifc ();
  reg_funsel_sequencer #(.NBits(16), .Depth(4), .CntBits(4)) dut (
    .clock(clock),
    .reset(reset),
    .cmd(ifc),
    .funsel(funsel),
    .e(e),
    .i(i),
    .busy(busy),
    .done(done),
`ifdef REG_SEQ_SHADOW_EN
    .shadow_q(shadow_q),
`endif
    .fifo_level(fifo_level)
  );
  always #5 clock = ~clock;
  typedef struct {
    logic [1:0] f;
    logic [15:0] d;
    logic last;
    logic [15:0] sh;
  } rec_t;
  rec_t exp_q[$];
  rec_t r;
  int checks = 0;
  int errors = 0;
  int acc_lvl, n;
  logic [15:0] sh = '0;
  logic prev_e = 1'b0, prev_last = 1'b0, cur_last;
  logic [15:0] prev_sh = '0;
  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", tag, act, exp);
    end
  endtask
  task automatic expect_cmd(input logic [1:0] op, input logic [15:0] d, input logic [3:0] c);
    int np = op[1] ? int'(c) + 1 : 1;
    for (int k = 0; k < np; k++) begin
      sh = op == 2'b00 ? 16'h0 : op == 2'b01 ? d : op == 2'b10 ? sh - 16'h1 : sh + 16'h1;
      exp_q.push_back('{op, d, k == np - 1, sh});
    end
  endtask
  task automatic send(input logic [1:0] op, input logic [15:0] d, input logic [3:0] c);
    int t = 0;
    @(negedge clock);
    ifc.cmd_valid = 1'b1;
    ifc.cmd_op = op;
    ifc.cmd_data = d;
    ifc.cmd_count = c;
    while (!ifc.cmd_ready && t < 200) begin
      @(negedge clock);
      t++;
    end
    chk("accept", ifc.cmd_ready, 1);
    acc_lvl = int'(fifo_level);
    if (ifc.cmd_ready) expect_cmd(op, d, c);
    @(posedge clock);
    #1 ifc.cmd_valid = 1'b0;
  endtask
  task automatic wait_e(output int cyc);
    cyc = 0;
    do begin
      @(negedge clock);
      cyc++;
    end while (!e && cyc < 100);
    chk("wait_e", e, 1);
  endtask
  task automatic wait_idle();
    int t = 0;
    do begin
      @(negedge clock);
      t++;
    end while (busy && t < 300);
    chk("idle", busy, 0);
    chk("drain", exp_q.size(), 0);
  endtask
  always @(negedge clock) begin
    if (reset) begin
      prev_e = 1'b0;
      prev_last = 1'b0;
    end else begin
      chk("done", done, prev_e & prev_last);
`ifdef REG_SEQ_SHADOW_EN
      if (prev_e) chk("shadow", shadow_q, prev_sh);
`endif
      if (e && prev_e) chk("e_width", e, 0);
      cur_last = 1'b0;
      if (e) begin
        if (exp_q.size() == 0) chk("e_extra", e, 0);
        else begin
          r = exp_q.pop_front();
          chk("funsel", funsel, r.f);
          if (r.f == 2'b01) chk("i", i, r.d);
          cur_last = r.last;
          prev_sh = r.sh;
        end
      end
      prev_last = cur_last;
      prev_e = e;
    end
  end
  initial begin
    reset = 1'b1;
    ifc.cmd_valid = 1'b0;
    ifc.cmd_op = 2'b00;
    ifc.cmd_data = '0;
    ifc.cmd_count = '0;
    @(negedge clock);
    chk("rst_e", e, 0);
    chk("rst_funsel", funsel, 0);
    chk("rst_i", i, 0);
    chk("rst_done", done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_level", fifo_level, 0);
    @(negedge clock);
    reset = 1'b0;
    #1 chk("rst_ready", ifc.cmd_ready, 1);
    // single load: exact latency
    send(2'b01, 16'h1234, 4'd0);
    @(negedge clock);
    chk("t1_busy", busy, 1);
    chk("t1_e0", e, 0);
    @(negedge clock);
    chk("t1_funsel", funsel, 2'b01);
    chk("t1_i", i, 16'h1234);
    chk("t1_e_setup", e, 0);
    @(negedge clock);
    chk("t1_e_pulse", e, 1);
    @(negedge clock);
    chk("t1_e_gap", e, 0);
    chk("t1_done", done, 1);
    @(negedge clock);
    chk("t1_done_off", done, 0);
    chk("t1_idle", busy, 0);
`ifdef REG_SEQ_SHADOW_EN
    chk("t1_shadow", shadow_q, 16'h1234);
`endif
    // inc x3: pulses two cycles apart
    send(2'b11, 16'h0, 4'd2);
    wait_e(n);
    chk("t2_first", n, 3);
    wait_e(n);
    chk("t2_gap1", n, 2);
    wait_e(n);
    chk("t2_gap2", n, 2);
    wait_idle();
`ifdef REG_SEQ_SHADOW_EN
    chk("t2_shadow", shadow_q, 16'h1237);
`endif
    // clear then dec wraps
    send(2'b00, 16'h0, 4'd0);
    send(2'b10, 16'h0, 4'd0);
    wait_idle();
`ifdef REG_SEQ_SHADOW_EN
    chk("t3_shadow", shadow_q, 16'hFFFF);
`endif
    // long burst, then fill the FIFO
    send(2'b11, 16'h0, 4'd15);
    send(2'b01, 16'hBEEF, 4'd0);
    send(2'b10, 16'h0, 4'd1);
    send(2'b00, 16'h0, 4'd0);
    send(2'b11, 16'h0, 4'd3);
    @(negedge clock);
    chk("t4_level", fifo_level, 4);
    chk("t4_ready", ifc.cmd_ready, 0);
    send(2'b01, 16'h0F0F, 4'd0);
    chk("t4_acc_lvl", acc_lvl, 3);
    wait_idle();
`ifdef REG_SEQ_SHADOW_EN
    chk("t4_shadow", shadow_q, sh);
`endif
    // reset in the middle of a burst
    send(2'b11, 16'h7777, 4'd15);
    send(2'b01, 16'h5A5A, 4'd0);
    wait_e(n);
    wait_e(n);
    #1 reset = 1'b1;
    #1;
    chk("t5_e", e, 0);
    chk("t5_funsel", funsel, 0);
    chk("t5_i", i, 0);
    chk("t5_level", fifo_level, 0);
    chk("t5_busy", busy, 0);
`ifdef REG_SEQ_SHADOW_EN
    chk("t5_shadow", shadow_q, 0);
`endif
    exp_q.delete();
    sh = '0;
    @(negedge clock);
    #2 reset = 1'b0;
    repeat (6) @(negedge clock);
    chk("t5_quiet", busy, 0);
    chk("t5_ready", ifc.cmd_ready, 1);
    // two queued loads: no IDLE between them
    send(2'b01, 16'h00AA, 4'd0);
    send(2'b01, 16'h0055, 4'd0);
    wait_e(n);
    chk("t6_i1", i, 16'h00AA);
    wait_e(n);
    chk("t6_spacing", n, 3);
    chk("t6_i2", i, 16'h0055);
    wait_idle();
`ifdef REG_SEQ_SHADOW_EN
    chk("t6_shadow", shadow_q, 16'h0055);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
